// File: rtl/rr_sel41_arbiter.sv
// Round-robin arbiter in front of the 4-to-1 selector: one-hot grant plus
// the selector's select lines, with a hold quantum that forces handover.
module rr_sel41_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [3:0] iReq,
    output logic [3:0] oGnt,
    output logic       oS1,
    output logic       oS0,
    output logic       oValid,
    output logic       oPreempt
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nx;
    logic [1:0]       ptr, ptr_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [3:0]       gnt_nx;
    logic [1:0]       sel, sel_nx;
    logic             valid_nx;
    logic             preempt_nx;
    logic [3:0]       others;
    logic [1:0]       win;

    // First set bit of req at or after base, scanning upward modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
        logic [1:0] idx;
        logic       found;
        rr_pick = base;
        found   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = base + 2'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            cnt      <= '0;
            oGnt     <= 4'd0;
            sel      <= 2'd0;
            oValid   <= 1'b0;
            oPreempt <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            cnt      <= cnt_nx;
            oGnt     <= gnt_nx;
            sel      <= sel_nx;
            oValid   <= valid_nx;
            oPreempt <= preempt_nx;
        end
    end

    assign oS1 = sel[1];
    assign oS0 = sel[0];

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        cnt_nx     = cnt;
        gnt_nx     = oGnt;
        sel_nx     = sel;
        valid_nx   = oValid;
        preempt_nx = 1'b0;
        others     = iReq & ~(4'b0001 << sel);
        win        = 2'd0;

        case (state)
            IDLE: begin
                gnt_nx   = 4'd0;
                valid_nx = 1'b0;
                if (iReq != 4'd0) begin
                    win      = rr_pick(iReq, ptr);
                    state_nx = GRANT;
                    gnt_nx   = 4'b0001 << win;
                    sel_nx   = win;
                    valid_nx = 1'b1;
                    cnt_nx   = '0;
                    ptr_nx   = win + 2'd1;
                end
            end
            GRANT: begin
                cnt_nx = cnt + 1'b1;
                if (!iReq[sel] || cnt == LAST) begin
                    // Release wins over expiry; both hand over from owner+1.
                    if (others != 4'd0) begin
                        win        = rr_pick(others, sel + 2'd1);
                        gnt_nx     = 4'b0001 << win;
                        sel_nx     = win;
                        cnt_nx     = '0;
                        ptr_nx     = win + 2'd1;
                        preempt_nx = iReq[sel];
                    end else if (!iReq[sel]) begin
                        state_nx = IDLE;
                        gnt_nx   = 4'd0;
                        valid_nx = 1'b0;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = '0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rr_sel41_arbiter.sv
// Directed bench for rr_sel41_arbiter; observed vector is
// {oGnt[3:0], oS1, oS0, oValid, oPreempt}.
module tb_rr_sel41_arbiter;

    logic       iClk;
    logic       iRst_n;
    logic [3:0] iReq;
    logic [3:0] oGnt;
    logic       oS1;
    logic       oS0;
    logic       oValid;
    logic       oPreempt;
    logic [7:0] obs;

    int checks = 0;
    int errors = 0;

    rr_sel41_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iReq    (iReq),
        .oGnt    (oGnt),
        .oS1     (oS1),
        .oS0     (oS0),
        .oValid  (oValid),
        .oPreempt(oPreempt)
    );

    assign obs = {oGnt, oS1, oS0, oValid, oPreempt};

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic reset_pulse();
        #2 iRst_n = 1'b0;
        #2 iRst_n = 1'b1;
    endtask

    task automatic test_reset();
        iReq   = 4'b1010;
        iRst_n = 1'b0;
        #3;
        checks++;
        if (obs !== 8'b0000_0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 8'b0000_0000);
        end
        step();
        iReq = 4'b0000;
        #2 iRst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs !== 8'b0000_0000) begin
                errors++;
                $display("FAIL reset_idle_%0d: got %b expected %b", i, obs, 8'b0000_0000);
            end
        end
    endtask

    task automatic test_single();
        iReq = 4'b0100;
        step();
        checks++;
        if (obs !== 8'b0100_1010) begin
            errors++;
            $display("FAIL single_grant: got %b expected %b", obs, 8'b0100_1010);
        end
        iReq = 4'b0000;
        step();
        // Select lines keep their last value while idle.
        checks++;
        if (obs !== 8'b0000_1000) begin
            errors++;
            $display("FAIL single_release: got %b expected %b", obs, 8'b0000_1000);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_g;
        logic [1:0] exp_s;
        reset_pulse();
        iReq = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            exp_s = 2'(k);
            exp_g = 4'b0001 << exp_s;
            for (int c = 0; c < 2; c++) begin
                step();
                checks++;
                if (obs !== {exp_g, exp_s, 2'b10}) begin
                    errors++;
                    $display("FAIL rotate_k%0d_c%0d: got %b expected %b", k, c, obs, {exp_g, exp_s, 2'b10});
                end
            end
            iReq[k] = 1'b0;
        end
        step();
        checks++;
        if (obs !== 8'b0000_1100) begin
            errors++;
            $display("FAIL rotate_idle: got %b expected %b", obs, 8'b0000_1100);
        end
        iReq = 4'b1111;
        step();
        checks++;
        if (obs !== 8'b0001_0010) begin
            errors++;
            $display("FAIL rotate_wrap: got %b expected %b", obs, 8'b0001_0010);
        end
        iReq = 4'b0000;
        step();
    endtask

    task automatic test_preempt();
        int held;
        iReq = 4'b0010;
        step();
        held = 0;
        if (obs === 8'b0010_0110) held++;
        iReq = 4'b1010;
        for (int i = 0; i < 7; i++) begin
            step();
            if (obs === 8'b0010_0110) held++;
        end
        checks++;
        if (held !== 8) begin
            errors++;
            $display("FAIL preempt_hold_cycles: got %0d expected %0d", held, 8);
        end
        step();
        checks++;
        if (obs !== 8'b1000_1111) begin
            errors++;
            $display("FAIL preempt_handover: got %b expected %b", obs, 8'b1000_1111);
        end
        step();
        checks++;
        if (obs !== 8'b1000_1110) begin
            errors++;
            $display("FAIL preempt_one_cycle: got %b expected %b", obs, 8'b1000_1110);
        end
        iReq = 4'b0000;
        step();
        checks++;
        if (obs !== 8'b0000_1100) begin
            errors++;
            $display("FAIL preempt_release: got %b expected %b", obs, 8'b0000_1100);
        end
    endtask

    task automatic test_lone_holder();
        int bad;
        iReq = 4'b0100;
        bad  = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (obs !== 8'b0100_1010) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL lone_holder: got %0d deviating cycles expected %0d", bad, 0);
        end
        iReq = 4'b0000;
        step();
    endtask

    task automatic test_mid_reset();
        iReq = 4'b1000;
        step();
        checks++;
        if (obs !== 8'b1000_1110) begin
            errors++;
            $display("FAIL midreset_pre: got %b expected %b", obs, 8'b1000_1110);
        end
        #2 iRst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 8'b0000_0000) begin
            errors++;
            $display("FAIL midreset_async_clear: got %b expected %b", obs, 8'b0000_0000);
        end
        iReq = 4'b1001;
        #1 iRst_n = 1'b1;
        step();
        checks++;
        if (obs !== 8'b0001_0010) begin
            errors++;
            $display("FAIL midreset_restart_ptr0: got %b expected %b", obs, 8'b0001_0010);
        end
        iReq = 4'b0000;
        step();
    endtask

    initial begin
        iReq   = 4'b0000;
        iRst_n = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_preempt();
        test_lone_holder();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_sel41_arbiter.md
Name: rr_sel41_arbiter

Overview:
Round-robin arbiter that shares the 4-to-1 4-bit selector datapath among four requesters. It drives the selector's two select lines and a one-hot grant. A grant is held until the owner drops its request or a hold quantum expires. It sits directly in front of the selector, with oS1/oS0 wired to the selector's iS1/iS0.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one requester may own the selector while others are waiting; legal range 2..15
CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
iClk  input  1  system clock, rising edge
iRst_n  input  1  asynchronous active-low reset
iReq  input  4  request vector; bit k is requester k and maps to selector input iCk
oGnt  output  4  one-hot grant, all zeros when idle
oS1  output  1  selector select MSB (index of granted requester, bit 1)
oS0  output  1  selector select LSB (index of granted requester, bit 0)
oValid  output  1  high while a grant is active, i.e. the selector output is meaningful
oPreempt  output  1  one-cycle pulse on the cycle a quantum-expiry handover is registered

Behaviour:
- All outputs are registered. Reset is asynchronous and active-low. During and after reset: oGnt=0, oS1=0, oS0=0, oValid=0, oPreempt=0, internal priority pointer ptr=0, hold counter cnt=0, state IDLE.
- Arbitration search: starting at the base index, scan ascending modulo 4 and pick the first set bit of iReq.
- State IDLE:
  - oGnt=0 and oValid=0; oS1/oS0 keep their last value.
  - If iReq≠0, search from ptr. On the next edge: state GRANT, oGnt=onehot(w), {oS1,oS0}=w, oValid=1, cnt=0, ptr=(w+1) mod 4.
  - Latency is one cycle from request to grant.
- State GRANT, owner g:
  - cnt increments by 1 every cycle.
  - Release: iReq[g]=0.
    - If other requests are pending, search from g+1 and hand over on the next edge with cnt=0. There is no idle bubble and oValid stays 1.
    - Otherwise go to IDLE on the next edge: oGnt=0, oValid=0.
  - Expiry: iReq[g]=1 and cnt==MAX_HOLD-1.
    - If another request is pending, search from g+1 excluding g, hand over on the next edge, and pulse oPreempt=1 for that one cycle.
    - If none is pending, g keeps the grant, cnt resets to 0 and no pulse is issued.
  - Otherwise hold the grant: oGnt, oS1 and oS0 are unchanged.
  - Release takes precedence over expiry when both hold on the same cycle; no pulse is issued.
- The grant never changes while iReq[g]=1 and cnt<MAX_HOLD-1, regardless of other requests.
- Simultaneous requests: the winner is the first set bit at or after ptr. Example: ptr=0 and iReq=4'b1111 grants requester 0, then 1, 2, 3 in order.
- Wrap-around: ptr and the search index are 2-bit modulo 4; after requester 3, requester 0 is next.
- Invariants:
  - oGnt is always one-hot or zero.
  - {oS1,oS0} always equals the index of the set oGnt bit whenever oValid=1.
  - oValid equals |oGnt.
- Reset asserted mid-grant clears everything immediately, without waiting for a clock. After release, arbitration restarts from ptr=0.

Test Plan:
- Reset/idle: iRst_n=0 with iReq=4'b1010 -> all outputs 0. Release reset with iReq=0 for 5 cycles -> oValid stays 0.
- Single request: iReq=4'b0100 from idle -> one edge later oGnt=4'b0100, oS1=1, oS0=0, oValid=1. Drop iReq -> next edge oGnt=0, oValid=0.
- Round-robin rotation: after reset, iReq=4'b1111 with each owner dropping its bit after 2 cycles of grant -> grants 0, 1, 2, 3 back-to-back with no oValid gap. Re-raise all bits -> next grant is 0 (wrap).
- Preemption: MAX_HOLD=8, requester 1 holds, requester 3 requests -> oGnt=4'b0010 for exactly 8 cycles, then 4'b1000 with oPreempt=1 for one cycle.
- Lone holder: requester 2 holds alone for 20 cycles -> grant never drops, oPreempt never pulses, {oS1,oS0}=2'b10 throughout.
- Mid-grant reset: assert iRst_n=0 asynchronously between edges while oGnt=4'b1000 -> outputs clear immediately. After release with iReq=4'b1001 -> requester 0 is granted (ptr reset to 0).
